// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges the EX-result (r0) and MEM-load (r1) writeback streams
// into a single registered regfile write port. Each requester owns one buffer
// entry; pending entries can be looked up for forwarding through q_addr.
// Build option: define WB_ARB_RR_EN to alternate grants on different-address
// conflicts; without it r1 always wins such conflicts.
module wb_port_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_valid,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_data,
  output logic          r0_ready,
  input  logic          r1_valid,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_data,
  output logic          r1_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  input  logic [AW-1:0] q_addr,
  output logic          q_hit,
  output logic [DW-1:0] q_data
);

  // Buffer entries; age1 set means buffer 1 holds the older entry.
  logic          b0_v, b1_v;
  logic [AW-1:0] b0_a, b1_a;
  logic [DW-1:0] b0_d, b1_d;
  logic          age1;

  logic elig0, elig1;
  logic drop0, drop1;
  logic gnt0, gnt1;
  logic free0, free1;
  logic keep0, keep1;
  logic acc0, acc1;

`ifdef WB_ARB_RR_EN
  // Set when the most recent grant went to buffer 1.
  logic last1;
`endif

  // Address 0 entries are never written; they just retire.
  assign elig0 = b0_v && (b0_a != '0);
  assign elig1 = b1_v && (b1_a != '0);
  assign drop0 = b0_v && (b0_a == '0);
  assign drop1 = b1_v && (b1_a == '0);

  // Pick at most one writable buffer this cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (elig0 && elig1) begin
      if (b0_a == b1_a) begin
        // Same destination: program order must be preserved.
        gnt1 = age1;
        gnt0 = !age1;
      end else begin
`ifdef WB_ARB_RR_EN
        gnt1 = !last1;
        gnt0 = last1;
`else
        gnt1 = 1'b1;
`endif
      end
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end
  end

  assign free0 = gnt0 || drop0;
  assign free1 = gnt1 || drop1;
  assign keep0 = b0_v && !free0;
  assign keep1 = b1_v && !free1;

  // A buffer that retires this cycle can be refilled at the same edge.
  assign r0_ready = !rst && (!b0_v || free0);
  assign r1_ready = !rst && (!b1_v || free1);
  assign acc0 = r0_valid && r0_ready;
  assign acc1 = r1_valid && r1_ready;

  // Buffer load/retire and relative age tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      b0_v <= 1'b0;
      b1_v <= 1'b0;
      b0_a <= '0;
      b1_a <= '0;
      b0_d <= '0;
      b1_d <= '0;
      age1 <= 1'b0;
    end else begin
      b0_v <= keep0 || acc0;
      b1_v <= keep1 || acc1;
      if (acc0) begin
        b0_a <= r0_addr;
        b0_d <= r0_data;
      end
      if (acc1) begin
        b1_a <= r1_addr;
        b1_d <= r1_data;
      end
      // A surviving entry is older than a fresh one; two fresh ones make r1 older.
      age1 <= (keep0 && keep1) ? age1 : !keep0;
    end
  end

`ifdef WB_ARB_RR_EN
  // Remember who was granted last for round-robin alternation.
  always_ff @(posedge clk) begin
    if (rst) begin
      last1 <= 1'b0;
    end else if (gnt0 || gnt1) begin
      last1 <= gnt1;
    end
  end
`endif

  // Registered regfile write port; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= gnt0 || gnt1;
      if (gnt1) begin
        waddr <= b1_a;
        wdata <= b1_d;
      end else if (gnt0) begin
        waddr <= b0_a;
        wdata <= b0_d;
      end
    end
  end

  // Forwarding lookup; the younger entry is the newest value for a register.
  logic m0, m1;
  always_comb begin
    m0     = !rst && b0_v && (q_addr != '0) && (b0_a == q_addr);
    m1     = !rst && b1_v && (q_addr != '0) && (b1_a == q_addr);
    q_hit  = m0 || m1;
    q_data = '0;
    if (m0 && m1) begin
      q_data = age1 ? b0_d : b1_d;
    end else if (m0) begin
      q_data = b0_d;
    end else if (m1) begin
      q_data = b1_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: vector table, directed contention/reset sequences and
// randomized traffic against a sequence-number based reference model.
module tb_wb_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NV = 15;
  localparam int unsigned NR = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_valid, r1_valid;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_data, r1_data;
  logic          r0_ready, r1_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] q_addr;
  logic          q_hit;
  logic [DW-1:0] q_data;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic [AW-1:0] qa);
    rst = rs;
    r0_valid = v0; r0_addr = a0; r0_data = d0;
    r1_valid = v1; r1_addr = a1; r1_data = d1;
    q_addr = qa;
  endtask

  // Comb expectations apply mid-cycle; we/waddr/wdata apply after the edge.
  typedef struct {
    logic          rs;
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [AW-1:0] qa;
    logic          rdy0;
    logic          rdy1;
    logic          hit;
    logic [DW-1:0] qd;
    logic          ewe;
    logic [AW-1:0] ewa;
    logic [DW-1:0] ewd;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input logic rs, input logic v0, input int a0, input int d0,
                              input logic v1, input int a1, input int d1, input int qa,
                              input logic rdy0, input logic rdy1, input logic hit, input int qd,
                              input logic ewe, input int ewa, input int ewd);
    vec_t v;
    v.rs = rs; v.v0 = v0; v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.v1 = v1; v.a1 = AW'(a1); v.d1 = DW'(d1); v.qa = AW'(qa);
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.hit = hit; v.qd = DW'(qd);
    v.ewe = ewe; v.ewa = AW'(ewa); v.ewd = DW'(ewd);
    return v;
  endfunction

  // Reference model state: entries ordered by acceptance sequence number.
  bit            mv[2];
  logic [AW-1:0] ma[2];
  logic [DW-1:0] md[2];
  int unsigned   mseq[2];
  int unsigned   seqc;
  bit            e_we;
  logic [AW-1:0] e_wa;
  logic [DW-1:0] e_wd;
`ifdef WB_ARB_RR_EN
  bit            mlast;
`endif

  initial begin
    //                rs v0 a0 d0    v1 a1 d1    qa  rdy0 rdy1 hit qd    we wa wd
    vecs[0]  = mk(1, 0, 0, 0,    0, 0, 0,    0,  0, 0, 0, 0,     0, 0, 0);
    vecs[1]  = mk(1, 1, 3, 'h11, 0, 0, 0,    3,  0, 0, 0, 0,     0, 0, 0);
    vecs[2]  = mk(0, 1, 3, 'h11, 0, 0, 0,    3,  1, 1, 0, 0,     0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0,    0, 0, 0,    3,  1, 1, 1, 'h11,  1, 3, 'h11);
    vecs[4]  = mk(0, 0, 0, 0,    0, 0, 0,    3,  1, 1, 0, 0,     0, 3, 'h11);
    vecs[5]  = mk(0, 1, 5, 'hA,  1, 5, 'hB,  5,  1, 1, 0, 0,     0, 3, 'h11);
    vecs[6]  = mk(0, 0, 0, 0,    0, 0, 0,    5,  0, 1, 1, 'hA,   1, 5, 'hB);
    vecs[7]  = mk(0, 0, 0, 0,    0, 0, 0,    5,  1, 1, 1, 'hA,   1, 5, 'hA);
    vecs[8]  = mk(0, 0, 0, 0,    0, 0, 0,    0,  1, 1, 0, 0,     0, 5, 'hA);
    vecs[9]  = mk(0, 0, 0, 0,    1, 0, 'hFF, 0,  1, 1, 0, 0,     0, 5, 'hA);
    vecs[10] = mk(0, 0, 0, 0,    0, 0, 0,    0,  1, 1, 0, 0,     0, 5, 'hA);
    vecs[11] = mk(0, 0, 0, 0,    0, 0, 0,    0,  1, 1, 0, 0,     0, 5, 'hA);
    vecs[12] = mk(0, 1, 7, 'h77, 1, 0, 'h55, 7,  1, 1, 0, 0,     0, 5, 'hA);
    vecs[13] = mk(0, 0, 0, 0,    0, 0, 0,    7,  1, 1, 1, 'h77,  1, 7, 'h77);
    vecs[14] = mk(0, 0, 0, 0,    0, 0, 0,    7,  1, 1, 0, 0,     0, 7, 'h77);

    drive(1, 0, '0, '0, 0, '0, '0, '0);
    @(posedge clk); #1;

    // Table-driven directed vectors.
    for (int i = 0; i < int'(NV); i++) begin
      drive(vecs[i].rs, vecs[i].v0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].qa);
      #1;
      chk($sformatf("vec%0d r0_ready", i), DW'(r0_ready), DW'(vecs[i].rdy0));
      chk($sformatf("vec%0d r1_ready", i), DW'(r1_ready), DW'(vecs[i].rdy1));
      chk($sformatf("vec%0d q_hit", i), DW'(q_hit), DW'(vecs[i].hit));
      chk($sformatf("vec%0d q_data", i), q_data, vecs[i].qd);
      @(posedge clk); #1;
      chk($sformatf("vec%0d we", i), DW'(we), DW'(vecs[i].ewe));
      chk($sformatf("vec%0d waddr", i), DW'(waddr), DW'(vecs[i].ewa));
      chk($sformatf("vec%0d wdata", i), wdata, vecs[i].ewd);
    end

    // Both requesters streaming different addresses.
    for (int k = 0; k <= 6; k++) begin
      logic er0, er1;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      drive(0, 1, AW'(9), DW'('hA0), 1, AW'(10), DW'('hB0), AW'(0));
      if (k == 0) begin
        er0 = 1'b1; er1 = 1'b1;
      end else begin
`ifdef WB_ARB_RR_EN
        er1 = (k % 2) == 1;
`else
        er1 = 1'b1;
`endif
        er0 = !er1;
      end
      ea = er1 ? AW'(10) : AW'(9);
      ed = er1 ? DW'('hB0) : DW'('hA0);
      #1;
      chk($sformatf("stream%0d r0_ready", k), DW'(r0_ready), DW'(er0));
      chk($sformatf("stream%0d r1_ready", k), DW'(r1_ready), DW'(er1));
      @(posedge clk); #1;
      chk($sformatf("stream%0d we", k), DW'(we), DW'(k != 0));
      if (k != 0) begin
        chk($sformatf("stream%0d waddr", k), DW'(waddr), DW'(ea));
        chk($sformatf("stream%0d wdata", k), wdata, ed);
      end
    end

    // One-cycle reset with both buffers occupied.
    drive(1, 1, AW'(9), DW'('hA0), 1, AW'(10), DW'('hB0), AW'(9));
    #1;
    chk("rst r0_ready", DW'(r0_ready), DW'(0));
    chk("rst r1_ready", DW'(r1_ready), DW'(0));
    chk("rst q_hit", DW'(q_hit), DW'(0));
    @(posedge clk); #1;
    chk("rst we", DW'(we), DW'(0));
    chk("rst waddr", DW'(waddr), DW'(0));
    chk("rst wdata", wdata, DW'(0));
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, '0, '0, 0, '0, '0, AW'(9));
      #1;
      chk($sformatf("postrst%0d r0_ready", k), DW'(r0_ready), DW'(1));
      chk($sformatf("postrst%0d r1_ready", k), DW'(r1_ready), DW'(1));
      chk($sformatf("postrst%0d q_hit", k), DW'(q_hit), DW'(0));
      @(posedge clk); #1;
      chk($sformatf("postrst%0d we", k), DW'(we), DW'(0));
    end

    // Randomized traffic against the reference model.
    mv[0] = 0; mv[1] = 0; ma[0] = '0; ma[1] = '0; md[0] = '0; md[1] = '0;
    mseq[0] = 0; mseq[1] = 0; seqc = 1;
    e_we = 0; e_wa = '0; e_wd = '0;
`ifdef WB_ARB_RR_EN
    mlast = 0;
`endif
    for (int c = 0; c < int'(NR); c++) begin
      bit            rs;
      bit            vin[2];
      logic [AW-1:0] ain[2];
      logic [DW-1:0] din[2];
      logic [AW-1:0] qa;
      int            g;
      bit            el[2];
      bit            fr[2];
      bit            rd[2];
      bit            m[2];
      logic [DW-1:0] eqd;

      rs = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < 2; i++) begin
        vin[i] = ($urandom_range(0, 9) < 6);
        ain[i] = AW'($urandom_range(0, 3));
        din[i] = DW'($urandom);
      end
      qa = AW'($urandom_range(0, 3));
      drive(rs, vin[0], ain[0], din[0], vin[1], ain[1], din[1], qa);
      #1;
      if (rs) begin
        chk($sformatf("rnd%0d r0_ready", c), DW'(r0_ready), DW'(0));
        chk($sformatf("rnd%0d r1_ready", c), DW'(r1_ready), DW'(0));
        chk($sformatf("rnd%0d q_hit", c), DW'(q_hit), DW'(0));
        mv[0] = 0; mv[1] = 0;
        e_we = 0; e_wa = '0; e_wd = '0;
`ifdef WB_ARB_RR_EN
        mlast = 0;
`endif
      end else begin
        g = -1;
        for (int i = 0; i < 2; i++) el[i] = mv[i] && (ma[i] != '0);
        if (el[0] && el[1]) begin
          if (ma[0] == ma[1]) begin
            g = (mseq[0] < mseq[1]) ? 0 : 1;
          end else begin
`ifdef WB_ARB_RR_EN
            g = mlast ? 0 : 1;
`else
            g = 1;
`endif
          end
        end else if (el[0]) begin
          g = 0;
        end else if (el[1]) begin
          g = 1;
        end
        for (int i = 0; i < 2; i++) begin
          fr[i] = mv[i] && ((g == i) || (ma[i] == '0));
          rd[i] = !mv[i] || fr[i];
          m[i]  = mv[i] && (qa != '0) && (ma[i] == qa);
        end
        eqd = '0;
        if (m[0] && m[1]) eqd = (mseq[0] > mseq[1]) ? md[0] : md[1];
        else if (m[0]) eqd = md[0];
        else if (m[1]) eqd = md[1];
        chk($sformatf("rnd%0d r0_ready", c), DW'(r0_ready), DW'(rd[0]));
        chk($sformatf("rnd%0d r1_ready", c), DW'(r1_ready), DW'(rd[1]));
        chk($sformatf("rnd%0d q_hit", c), DW'(q_hit), DW'(m[0] || m[1]));
        chk($sformatf("rnd%0d q_data", c), q_data, eqd);
        if (g >= 0) begin
          e_we = 1; e_wa = ma[g]; e_wd = md[g];
`ifdef WB_ARB_RR_EN
          mlast = (g == 1);
`endif
        end else begin
          e_we = 0;
        end
        for (int i = 0; i < 2; i++) if (fr[i]) mv[i] = 0;
        // r1 takes the earlier sequence number on a simultaneous acceptance.
        if (vin[1] && rd[1]) begin
          mv[1] = 1; ma[1] = ain[1]; md[1] = din[1]; mseq[1] = seqc; seqc++;
        end
        if (vin[0] && rd[0]) begin
          mv[0] = 1; ma[0] = ain[0]; md[0] = din[0]; mseq[0] = seqc; seqc++;
        end
      end
      @(posedge clk); #1;
      chk($sformatf("rnd%0d we", c), DW'(we), DW'(e_we));
      chk($sformatf("rnd%0d waddr", c), DW'(waddr), DW'(e_wa));
      chk($sformatf("rnd%0d wdata", c), wdata, e_wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
